// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the parallel-in serial-out stage
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-index counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - word-to-bit serializer with one-entry hold for gapless streaming
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic [WIDTH-1:0] sh_next;

  assign load_ready = !hold_full_q;
  assign accept     = load_valid && load_ready;
  assign shifting   = (state_q == ST_SHIFT);
  assign last_bit   = (cnt_q == LAST);
  assign sh_next    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  assign ser_valid   = shifting;
  assign ser_out     = shifting ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign frame_start = shifting && (cnt_q == '0);
  assign frame_done  = shifting && last_bit;
  assign busy        = shifting || hold_full_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d    = load_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Held word always goes first; load_ready is low here so nothing newer can slip in.
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          sh_d  = load_data;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv0 = 1'b0, lv1 = 1'b0;
  logic [7:0] ld0 = '0,   ld1 = '0;
  logic       lr0, so0, sv0, fs0, fd0, bz0;
  logic       lr1, so1, sv1, fs1, fd1, bz1;

  int n_cmp = 0;
  int n_err = 0;

  // Expected entries: {ser_out, frame_start, frame_done}
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
    .ser_out(so0), .ser_valid(sv0), .frame_start(fs0), .frame_done(fd0), .busy(bz0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
    .ser_out(so1), .ser_valid(sv1), .frame_start(fs1), .frame_done(fd1), .busy(bz1)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [2:0] e;
    if (sv0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut0 unexpected bit: got %b expected none at %0t", {so0, fs0, fd0}, $time);
      end else begin
        e = q0.pop_front();
        check("dut0 bit/start/done", {29'd0, so0, fs0, fd0}, {29'd0, e});
      end
    end else begin
      check("dut0 idle outputs", {29'd0, so0, fs0, fd0}, 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (sv1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut1 unexpected bit: got %b expected none at %0t", {so1, fs1, fd1}, $time);
      end else begin
        e = q1.pop_front();
        check("dut1 bit/start/done", {29'd0, so1, fs1, fd1}, {29'd0, e});
      end
    end else begin
      check("dut1 idle outputs", {29'd0, so1, fs1, fd1}, 32'd4);
    end
  end

  // Called in the drive phase (#1 after a rising edge); returns in the drive phase after acceptance.
  task automatic send(input int sel, input logic [7:0] d);
    int  waited;
    bit  done;
    logic b;
    logic rdy;
    waited = 0;
    done   = 1'b0;
    if (sel == 0) begin lv0 = 1'b1; ld0 = d; end
    else          begin lv1 = 1'b1; ld1 = d; end
    while (!done && waited < 50) begin
      @(negedge clk);
      rdy = (sel == 0) ? lr0 : lr1;
      if (rdy === 1'b1) begin
        for (int i = 0; i < 8; i++) begin
          b = (sel == 0) ? d[7-i] : d[i];
          if (sel == 0) q0.push_back({b, (i == 0), (i == 7)});
          else          q1.push_back({b, (i == 0), (i == 7)});
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (sel == 0) lv0 = 1'b0;
    else          lv1 = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send timeout dut%0d: word %h not accepted within %0d cycles", sel, d, waited);
    end
  endtask

  initial begin
    int w;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset load_ready", lr0, 1);
    check("reset ser_valid", sv0, 0);
    check("reset busy", bz0, 0);
    check("reset dut1 load_ready", lr1, 1);
    check("reset dut1 idle bit", so1, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word: first bit one cycle after accept, last bit eight cycles after
    send(0, 8'hAA);
    @(negedge clk);
    check("AA first valid", sv0, 1);
    check("AA frame_start", fs0, 1);
    check("AA first bit", so0, 1);
    repeat (7) @(negedge clk);
    check("AA frame_done", fd0, 1);
    check("AA last bit", so0, 0);
    @(negedge clk);
    check("AA idle after", sv0, 0);
    @(posedge clk);
    #1;

    // Back-to-back through the hold register
    send(0, 8'hA5);
    send(0, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("b2b load_ready low", lr0, 0);
      check("b2b busy", bz0, 1);
      check("b2b contiguous", sv0, 1);
    end
    @(negedge clk);
    check("b2b load_ready back", lr0, 1);
    check("b2b second start", fs0, 1);
    repeat (8) @(negedge clk);
    check("b2b idle after", sv0, 0);
    @(posedge clk);
    #1;

    // Direct load exactly in the frame_done cycle
    send(0, 8'h12);
    repeat (7) @(posedge clk);
    #1;
    send(0, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("direct hold never full", lr0, 1);
      check("direct contiguous", sv0, 1);
    end
    @(negedge clk);
    check("direct idle after", sv0, 0);
    @(posedge clk);
    #1;

    // LSB-first instance, idle level high
    send(1, 8'h01);
    @(negedge clk);
    check("lsb first bit", so1, 1);
    check("lsb frame_start", fs1, 1);
    repeat (8) @(negedge clk);
    check("lsb idle valid", sv1, 0);
    check("lsb idle level", so1, 1);
    @(posedge clk);
    #1;
    send(1, 8'hB4);
    repeat (9) @(posedge clk);
    #1;

    // Reset while bit 3 of 8'hFF is on the line
    send(0, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("rst mid no frame_done", fd0, 0);
    check("rst mid ser_valid", sv0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post rst load_ready", lr0, 1);
    check("post rst ser_valid", sv0, 0);
    check("post rst ser_out", so0, 0);
    check("post rst busy", bz0, 0);
    @(posedge clk);
    #1;
    send(0, 8'h0F);
    @(negedge clk);
    check("0F frame_start", fs0, 1);
    check("0F first bit", so0, 0);

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 40) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("dut0 all bits seen", q0.size(), 0);
    check("dut1 all bits seen", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
